// File: rtl/mc_scoreboard_unit_if.sv
// ---------------------------------------------------------------------------
// mc_scoreboard_unit_if
// Bundles the ID-stage hazard query, multi-cycle unit completion, write-back
// arbitration and status signals of mc_scoreboard_unit.
//   slave  : the scoreboard itself (consumes i*, produces o*)
//   master : the pipeline / environment (produces i*, consumes o*)
// Inputs : iID_Valid, iID_Rs1/Rs2 (+Used), iID_Rd (+RdWrite), iID_Unit,
//          iIssue, iMC_Done, iWB_Free, iAbort
// Outputs: oID_Stall, oWB_Grant, oWB_Rd, oFwdRs1/2, oFwdSel, oUnitBusy,
//          oBusyVec, oTimeout
// ---------------------------------------------------------------------------
interface mc_scoreboard_unit_if #(
    parameter int NREG = 32,
    parameter int REGW = 5,
    parameter int NMC  = 2,
    parameter int SELW = 1
);
    logic            iID_Valid;
    logic [REGW-1:0] iID_Rs1;
    logic [REGW-1:0] iID_Rs2;
    logic            iID_Rs1Used;
    logic            iID_Rs2Used;
    logic [REGW-1:0] iID_Rd;
    logic            iID_RdWrite;
    logic [NMC-1:0]  iID_Unit;
    logic            iIssue;
    logic [NMC-1:0]  iMC_Done;
    logic            iWB_Free;
    logic            iAbort;

    logic            oID_Stall;
    logic [NMC-1:0]  oWB_Grant;
    logic [REGW-1:0] oWB_Rd;
    logic            oFwdRs1;
    logic            oFwdRs2;
    logic [SELW-1:0] oFwdSel;
    logic [NMC-1:0]  oUnitBusy;
    logic [NREG-1:0] oBusyVec;
    logic [NMC-1:0]  oTimeout;

    modport slave (
        input  iID_Valid, iID_Rs1, iID_Rs2, iID_Rs1Used, iID_Rs2Used,
               iID_Rd, iID_RdWrite, iID_Unit, iIssue, iMC_Done, iWB_Free, iAbort,
        output oID_Stall, oWB_Grant, oWB_Rd, oFwdRs1, oFwdRs2, oFwdSel,
               oUnitBusy, oBusyVec, oTimeout
    );

    modport master (
        output iID_Valid, iID_Rs1, iID_Rs2, iID_Rs1Used, iID_Rs2Used,
               iID_Rd, iID_RdWrite, iID_Unit, iIssue, iMC_Done, iWB_Free, iAbort,
        input  oID_Stall, oWB_Grant, oWB_Rd, oFwdRs1, oFwdRs2, oFwdSel,
               oUnitBusy, oBusyVec, oTimeout
    );
endinterface

// File: rtl/mc_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// mc_scoreboard_unit
// Per-register busy scoreboard for NMC independently running multi-cycle
// units. Produces the ID stall (RAW / WAW / structural), arbitrates the shared
// write-back port among completing units (lowest index first), bypasses the
// granted result to ID in its grant cycle and flags units that overrun
// TIMEOUT cycles in RUN.
// Ports:
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   bus          : mc_scoreboard_unit_if.slave (ID query, completion, WB
//                  arbitration, status)
// ---------------------------------------------------------------------------
module mc_scoreboard_unit #(
    parameter int NREG    = 32,
    parameter int REGW    = 5,
    parameter int NMC     = 2,
    parameter int SELW    = 1,
    parameter int TIMEOUT = 64,
    parameter int TOW     = 7
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    mc_scoreboard_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_WB = 2'd2
    } unit_state_e;

    // Register 0 is architecturally constant and must never read as busy.
    localparam logic [NREG-1:0] R0_KEEP_MASK = {{(NREG-1){1'b1}}, 1'b0};
    localparam logic [TOW-1:0]  CNT_LAST     = TOW'(TIMEOUT - 1);

    unit_state_e     state_q [NMC];
    logic [REGW-1:0] rd_q    [NMC];
    logic [TOW-1:0]  cnt_q   [NMC];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NMC-1:0]  timeout_q;

    logic [NMC-1:0]  unit_busy_s;
    logic [NMC-1:0]  req_s;
    logic [NMC-1:0]  grant_s;
    logic [NMC-1:0]  issue_s;
    logic [NMC-1:0]  fire_s;
    logic            grant_any_s;
    logic [SELW-1:0] gsel_s;
    logic [REGW-1:0] grant_rd_s;
    logic            fwd1_s;
    logic            fwd2_s;
    logic            raw1_s;
    logic            raw2_s;
    logic            waw_s;
    logic            struct_s;
    logic            stall_s;
    logic [NREG-1:0] busy_set_s;
    logic [NREG-1:0] busy_clr_s;

    // Per-unit status, write-back requests and timeout detection.
    always_comb begin
        unit_busy_s = '0;
        req_s       = '0;
        fire_s      = '0;
        for (int i = 0; i < NMC; i++) begin
            unit_busy_s[i] = (state_q[i] != ST_IDLE);
            // A unit finishing this very cycle competes alongside the waiters.
            req_s[i]  = (state_q[i] == ST_WAIT_WB) ||
                        ((state_q[i] == ST_RUN) && bus.iMC_Done[i]);
            fire_s[i] = (state_q[i] == ST_RUN) && !bus.iMC_Done[i] &&
                        (cnt_q[i] == CNT_LAST);
        end
    end

    // Fixed-priority write-back arbiter; walking downward lets the lowest index win.
    always_comb begin
        grant_s = '0;
        gsel_s  = '0;
        for (int i = NMC - 1; i >= 0; i--) begin
            if (bus.iWB_Free && req_s[i]) begin
                grant_s    = '0;
                grant_s[i] = 1'b1;
                gsel_s     = SELW'(i);
            end else begin
                grant_s = grant_s;
            end
        end
        grant_any_s = |grant_s;
        if (grant_any_s) begin
            grant_rd_s = rd_q[gsel_s];
        end else begin
            grant_rd_s = '0;
        end
    end

    // ID hazard evaluation against the registered scoreboard plus same-cycle bypass.
    always_comb begin
        // A granted rd is never 0 when it matches a nonzero source, so the
        // bypass qualifier also implies the register was busy.
        fwd1_s   = bus.iID_Valid && bus.iID_Rs1Used && (bus.iID_Rs1 != '0) &&
                   grant_any_s && (grant_rd_s == bus.iID_Rs1);
        fwd2_s   = bus.iID_Valid && bus.iID_Rs2Used && (bus.iID_Rs2 != '0) &&
                   grant_any_s && (grant_rd_s == bus.iID_Rs2);
        raw1_s   = bus.iID_Rs1Used && (bus.iID_Rs1 != '0) && busy_q[bus.iID_Rs1] &&
                   !(grant_any_s && (grant_rd_s == bus.iID_Rs1));
        raw2_s   = bus.iID_Rs2Used && (bus.iID_Rs2 != '0) && busy_q[bus.iID_Rs2] &&
                   !(grant_any_s && (grant_rd_s == bus.iID_Rs2));
        // WAW deliberately ignores the bypass: the write-back and the new
        // claim on the same rd would otherwise collide in the scoreboard.
        waw_s    = bus.iID_RdWrite && (bus.iID_Rd != '0) && busy_q[bus.iID_Rd];
        struct_s = |(bus.iID_Unit & unit_busy_s);
        stall_s  = bus.iID_Valid && (raw1_s || raw2_s || waw_s || struct_s);
        for (int i = 0; i < NMC; i++) begin
            issue_s[i] = bus.iIssue && bus.iID_Valid && bus.iID_Unit[i] &&
                         !stall_s && !bus.iAbort;
        end
    end

    // Scoreboard next state: clears from grants/timeouts first, then sets (set wins).
    always_comb begin
        busy_set_s = '0;
        busy_clr_s = '0;
        for (int i = 0; i < NMC; i++) begin
            if (grant_s[i] || fire_s[i]) begin
                busy_clr_s[rd_q[i]] = 1'b1;
            end else begin
                busy_clr_s = busy_clr_s;
            end
            if (issue_s[i] && bus.iID_RdWrite && (bus.iID_Rd != '0)) begin
                busy_set_s[bus.iID_Rd] = 1'b1;
            end else begin
                busy_set_s = busy_set_s;
            end
        end
        if (bus.iAbort) begin
            busy_d = '0;
        end else begin
            busy_d = ((busy_q & ~busy_clr_s) | busy_set_s) & R0_KEEP_MASK;
        end
    end

    // Per-unit FSMs, latched rd, RUN counters, scoreboard and sticky timeout flags.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < NMC; i++) begin
                state_q[i] <= ST_IDLE;
                rd_q[i]    <= '0;
                cnt_q[i]   <= '0;
            end
            busy_q    <= '0;
            timeout_q <= '0;
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NMC; i++) begin
                if (fire_s[i]) begin
                    timeout_q[i] <= 1'b1;
                end else begin
                    timeout_q[i] <= timeout_q[i];
                end
                if (bus.iAbort) begin
                    state_q[i] <= ST_IDLE;
                    cnt_q[i]   <= '0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (issue_s[i]) begin
                                state_q[i] <= ST_RUN;
                                // Non-writing ops latch rd 0 so they never bypass.
                                rd_q[i]    <= bus.iID_RdWrite ? bus.iID_Rd : '0;
                                cnt_q[i]   <= '0;
                            end else begin
                                state_q[i] <= ST_IDLE;
                            end
                        end
                        ST_RUN: begin
                            if (bus.iMC_Done[i]) begin
                                state_q[i] <= grant_s[i] ? ST_IDLE : ST_WAIT_WB;
                            end else if (fire_s[i]) begin
                                state_q[i] <= ST_IDLE;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                        ST_WAIT_WB: begin
                            if (grant_s[i]) begin
                                state_q[i] <= ST_IDLE;
                            end else begin
                                state_q[i] <= ST_WAIT_WB;
                            end
                        end
                        default: begin
                            state_q[i] <= ST_IDLE;
                            cnt_q[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.oID_Stall = stall_s;
    assign bus.oWB_Grant = grant_s;
    assign bus.oWB_Rd    = grant_rd_s;
    assign bus.oFwdRs1   = fwd1_s;
    assign bus.oFwdRs2   = fwd2_s;
    assign bus.oFwdSel   = gsel_s;
    assign bus.oUnitBusy = unit_busy_s;
    assign bus.oBusyVec  = busy_q;
    assign bus.oTimeout  = timeout_q;

endmodule

// File: tb/tb_mc_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_scoreboard_unit
// Directed scenarios followed by random traffic. The driver applies inputs
// shortly after each rising edge, asks a behavioural model what the outputs
// must be this cycle and queues that expectation; a separate monitor pops
// and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_scoreboard_unit;

    localparam int NREG    = 32;
    localparam int REGW    = 5;
    localparam int NMC     = 2;
    localparam int SELW    = 1;
    localparam int TIMEOUT = 64;
    localparam int TOW     = 7;

    typedef struct packed {
        logic            stall;
        logic [NMC-1:0]  grant;
        logic [REGW-1:0] wbrd;
        logic            f1;
        logic            f2;
        logic [SELW-1:0] sel;
        logic [NMC-1:0]  ubusy;
        logic [NREG-1:0] busy;
        logic [NMC-1:0]  tout;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    mc_scoreboard_unit_if #(.NREG(NREG), .REGW(REGW), .NMC(NMC), .SELW(SELW)) bus ();

    mc_scoreboard_unit #(
        .NREG(NREG), .REGW(REGW), .NMC(NMC), .SELW(SELW), .TIMEOUT(TIMEOUT), .TOW(TOW)
    ) dut (
        .iCLK  (clk),
        .iRST_n(rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    // stimulus for the current cycle
    logic            t_valid, t_u1, t_u2, t_rdw, t_issue, t_free, t_abort;
    logic [REGW-1:0] t_rs1, t_rs2, t_rd;
    logic [NMC-1:0]  t_unit, t_done;

    // reference model: which units hold work, which already finished and
    // are waiting for the port, how many RUN cycles elapsed, and their rd
    bit             m_act  [NMC];
    bit             m_wait [NMC];
    int             m_age  [NMC];
    int             m_rd   [NMC];
    bit [NMC-1:0]   m_to;

    function automatic obs_t sample();
        obs_t o;
        o.stall = bus.oID_Stall;
        o.grant = bus.oWB_Grant;
        o.wbrd  = bus.oWB_Rd;
        o.f1    = bus.oFwdRs1;
        o.f2    = bus.oFwdRs2;
        o.sel   = bus.oFwdSel;
        o.ubusy = bus.oUnitBusy;
        o.busy  = bus.oBusyVec;
        o.tout  = bus.oTimeout;
        return o;
    endfunction

    task automatic check(input obs_t got, input obs_t want, input string name, input int c);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, want);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NMC; u++) begin
            m_act[u]  = 1'b0;
            m_wait[u] = 1'b0;
            m_age[u]  = 0;
            m_rd[u]   = 0;
        end
        m_to = '0;
    endtask

    task automatic model_cycle(output obs_t e);
        logic [NREG-1:0] bv;
        int g;
        int grd;
        bit r1, r2, w, st, stall, iss_ok;
        // busy registers are exactly the pending destinations of live units
        bv = '0;
        for (int u = 0; u < NMC; u++)
            if (m_act[u] && m_rd[u] != 0) bv[m_rd[u]] = 1'b1;
        g = -1;
        if (t_free)
            for (int u = NMC - 1; u >= 0; u--)
                if (m_act[u] && (m_wait[u] || t_done[u])) g = u;
        grd = (g >= 0) ? m_rd[g] : 0;
        e.f1  = t_valid && t_u1 && t_rs1 != 0 && g >= 0 && grd == int'(t_rs1);
        e.f2  = t_valid && t_u2 && t_rs2 != 0 && g >= 0 && grd == int'(t_rs2);
        r1    = t_u1 && t_rs1 != 0 && bv[t_rs1] && !(g >= 0 && grd == int'(t_rs1));
        r2    = t_u2 && t_rs2 != 0 && bv[t_rs2] && !(g >= 0 && grd == int'(t_rs2));
        w     = t_rdw && t_rd != 0 && bv[t_rd];
        st    = 1'b0;
        for (int u = 0; u < NMC; u++) if (t_unit[u] && m_act[u]) st = 1'b1;
        stall  = t_valid && (r1 || r2 || w || st);
        iss_ok = t_issue && t_valid && !stall && !t_abort;
        e.stall = stall;
        e.grant = '0;
        if (g >= 0) e.grant[g] = 1'b1;
        e.wbrd = REGW'(grd);
        e.sel  = (g >= 0) ? SELW'(g) : '0;
        for (int u = 0; u < NMC; u++) e.ubusy[u] = m_act[u];
        e.busy = bv;
        e.tout = m_to;
        // advance to the next cycle
        for (int u = 0; u < NMC; u++) begin
            if (m_act[u]) begin
                if (m_wait[u]) begin
                    if (g == u) m_act[u] = 1'b0;
                end else if (t_done[u]) begin
                    if (g == u) m_act[u] = 1'b0;
                    else        m_wait[u] = 1'b1;
                end else if (m_age[u] == TIMEOUT) begin
                    m_to[u]  = 1'b1;
                    m_act[u] = 1'b0;
                end else begin
                    m_age[u]++;
                end
            end else if (iss_ok && t_unit[u]) begin
                m_act[u]  = 1'b1;
                m_wait[u] = 1'b0;
                m_age[u]  = 1;
                m_rd[u]   = t_rdw ? int'(t_rd) : 0;
            end
        end
        if (t_abort)
            for (int u = 0; u < NMC; u++) begin
                m_act[u]  = 1'b0;
                m_wait[u] = 1'b0;
            end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        bus.iID_Valid   = t_valid;
        bus.iID_Rs1     = t_rs1;
        bus.iID_Rs2     = t_rs2;
        bus.iID_Rs1Used = t_u1;
        bus.iID_Rs2Used = t_u2;
        bus.iID_Rd      = t_rd;
        bus.iID_RdWrite = t_rdw;
        bus.iID_Unit    = t_unit;
        bus.iIssue      = t_issue;
        bus.iMC_Done    = t_done;
        bus.iWB_Free    = t_free;
        bus.iAbort      = t_abort;
        model_cycle(e.o);
        e.cyc = cyc;
        cyc++;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic id_none();
        t_valid = 1'b0; t_rs1 = '0; t_rs2 = '0; t_u1 = 1'b0; t_u2 = 1'b0;
        t_rd = '0; t_rdw = 1'b0; t_unit = '0; t_issue = 1'b0;
    endtask

    task automatic id_instr(input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit rdw, input logic [NMC-1:0] unit);
        t_valid = 1'b1; t_rs1 = REGW'(rs1); t_u1 = u1; t_rs2 = REGW'(rs2); t_u2 = u2;
        t_rd = REGW'(rd); t_rdw = rdw; t_unit = unit; t_issue = 1'b1;
    endtask

    // monitor: compare every queued expectation on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(sample(), e.o, "outputs", e.cyc);
            end
        end
    end

    initial begin
        obs_t zero_o;
        zero_o = '0;
        rst_n  = 1'b0;
        id_none();
        t_done = '0; t_free = 1'b1; t_abort = 1'b0;
        bus.iID_Valid = 1'b0; bus.iID_Rs1 = '0; bus.iID_Rs2 = '0;
        bus.iID_Rs1Used = 1'b0; bus.iID_Rs2Used = 1'b0; bus.iID_Rd = '0;
        bus.iID_RdWrite = 1'b0; bus.iID_Unit = '0; bus.iIssue = 1'b0;
        bus.iMC_Done = '0; bus.iWB_Free = 1'b1; bus.iAbort = 1'b0;
        model_reset();
        #2;
        check(sample(), zero_o, "reset_state", -1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // dependent read of x5 behind a long unit-0 op, released via bypass
        id_instr(0, 0, 0, 0, 5, 1, 2'b01); tick();
        id_instr(5, 1, 0, 0, 0, 0, 2'b00); run(9);
        t_done = 2'b01; tick();
        t_done = 2'b00; id_none(); run(2);

        // independent op flows while x5 is busy
        id_instr(0, 0, 0, 0, 5, 1, 2'b01); tick();
        id_instr(2, 1, 3, 1, 4, 1, 2'b00); run(5);
        t_done = 2'b01; id_none(); tick();
        t_done = 2'b00; tick();

        // simultaneous completion, then a blocked write-back port
        id_instr(0, 0, 0, 0, 6, 1, 2'b01); tick();
        id_instr(0, 0, 0, 0, 7, 1, 2'b10); tick();
        id_none(); run(3);
        t_done = 2'b11; tick();
        t_done = 2'b00; run(2);
        id_instr(0, 0, 0, 0, 6, 1, 2'b01); tick();
        id_instr(0, 0, 0, 0, 7, 1, 2'b10); tick();
        id_none(); run(2);
        t_done = 2'b11; t_free = 1'b0; tick();
        t_done = 2'b00; run(2);
        t_free = 1'b1; id_instr(7, 1, 6, 1, 0, 0, 2'b00); run(3);
        id_none(); tick();

        // structural hazard on unit 0, then WAW on x5
        id_instr(0, 0, 0, 0, 5, 1, 2'b01); tick();
        id_instr(0, 0, 0, 0, 9, 1, 2'b01); run(3);
        id_instr(0, 0, 0, 0, 5, 1, 2'b00); run(2);
        t_done = 2'b01; tick();
        t_done = 2'b00; run(2);
        id_instr(0, 0, 0, 0, 9, 1, 2'b01); run(2);
        id_none(); t_done = 2'b01; tick();
        t_done = 2'b00; tick();

        // timeout on unit 0, flag survives an abort
        id_instr(0, 0, 0, 0, 5, 1, 2'b01); tick();
        id_instr(5, 1, 0, 0, 0, 0, 2'b00); run(TIMEOUT + 4);
        id_none(); t_abort = 1'b1; tick();
        t_abort = 1'b0; run(2);

        // abort with both units busy, and an otherwise clean issue during abort
        id_instr(0, 0, 0, 0, 10, 1, 2'b01); tick();
        id_instr(0, 0, 0, 0, 11, 1, 2'b10); tick();
        id_none(); run(2);
        id_instr(10, 1, 0, 0, 12, 1, 2'b01); t_abort = 1'b1; tick();
        t_abort = 1'b0; id_none(); run(2);
        id_instr(0, 0, 0, 0, 12, 1, 2'b01); t_abort = 1'b1; tick();
        t_abort = 1'b0; id_none(); run(2);

        // asynchronous reset while both units run
        id_instr(0, 0, 0, 0, 5, 1, 2'b01); tick();
        id_instr(5, 1, 0, 0, 6, 1, 2'b10); tick();
        id_instr(5, 1, 0, 0, 0, 0, 2'b00); run(3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check(sample(), zero_o, "async_reset", cyc);
        model_reset();
        id_none();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            t_valid = ($urandom_range(7) != 0);
            t_rs1   = REGW'($urandom_range(7));
            t_rs2   = REGW'($urandom_range(7));
            t_rd    = REGW'($urandom_range(7));
            t_u1    = ($urandom_range(1) == 1);
            t_u2    = ($urandom_range(1) == 1);
            t_rdw   = ($urandom_range(3) != 0);
            r       = int'($urandom_range(3));
            t_unit  = (r == 2) ? 2'b01 : (r == 3) ? 2'b10 : 2'b00;
            t_issue = ($urandom_range(7) != 0);
            for (int u = 0; u < NMC; u++) t_done[u] = ($urandom_range(5) == 0);
            t_free  = ($urandom_range(3) != 0);
            t_abort = ($urandom_range(99) == 0);
            tick();
        end
        id_none(); t_done = '0; t_free = 1'b1; t_abort = 1'b0;
        run(2);
        @(negedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
